// File: rtl/vram_arbiter.sv
// Shared VRAM arbiter: host byte port and display word port onto one single-ported word memory.
// Define VRAM_ARB_DISP_PRIORITY_EN for fixed display priority on ties; default is round-robin.
module vram_arbiter #(
  parameter int ADDRESS_WIDTH = 23,
  parameter int DATA_WIDTH    = 8,
  parameter int CORE_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [ADDRESS_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]    host_wdata,
  output logic [DATA_WIDTH-1:0]    host_rdata,
  output logic                     host_ack,
  input  logic                     disp_req,
  input  logic [ADDRESS_WIDTH-2:0] disp_addr,
  output logic [CORE_WIDTH-1:0]    disp_rdata,
  output logic                     disp_ack,
  output logic [ADDRESS_WIDTH-2:0] mem_addr,
  output logic                     mem_we,
  output logic [CORE_WIDTH-1:0]    mem_wdata,
  input  logic [CORE_WIDTH-1:0]    mem_rdata,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t                   state_q;
  logic                     owner_disp_q;
  logic                     op_wr_q;
  logic                     bsel_q;
  logic                     last_disp_q;
  logic [DATA_WIDTH-1:0]    holding_q;
  logic [DATA_WIDTH-1:0]    host_rdata_q;
  logic [CORE_WIDTH-1:0]    disp_rdata_q;
  logic                     host_ack_q;
  logic                     disp_ack_q;
  logic [ADDRESS_WIDTH-2:0] mem_addr_q;
  logic                     mem_we_q;
  logic [CORE_WIDTH-1:0]    mem_wdata_q;

  logic host_ok, disp_ok, host_even, host_mem, disp_wins_tie, grant_disp;

  // A requester still holds req during its own ack cycle; mask it so the
  // completed request is not accepted a second time.
  assign host_ok   = host_req & ~host_ack_q;
  assign disp_ok   = disp_req & ~disp_ack_q;
  assign host_even = host_ok & host_we & ~host_addr[0];
  assign host_mem  = host_ok & ~(host_we & ~host_addr[0]);

`ifdef VRAM_ARB_DISP_PRIORITY_EN
  assign disp_wins_tie = 1'b1;
`else
  assign disp_wins_tie = ~last_disp_q;
`endif

  assign grant_disp = disp_ok & (~host_mem | disp_wins_tie);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_disp_q <= 1'b0;
      op_wr_q      <= 1'b0;
      bsel_q       <= 1'b0;
      last_disp_q  <= 1'b0;
      holding_q    <= '0;
      host_rdata_q <= '0;
      disp_rdata_q <= '0;
      host_ack_q   <= 1'b0;
      disp_ack_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      host_ack_q <= 1'b0;
      disp_ack_q <= 1'b0;
      mem_we_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          // Even-byte writes never touch memory, so they complete alongside a display grant.
          if (host_even) begin
            holding_q  <= host_wdata;
            host_ack_q <= 1'b1;
          end
          if (grant_disp) begin
            owner_disp_q <= 1'b1;
            op_wr_q      <= 1'b0;
            mem_addr_q   <= disp_addr;
            state_q      <= ISSUE;
            if (host_mem) last_disp_q <= 1'b1;
          end else if (host_mem) begin
            owner_disp_q <= 1'b0;
            op_wr_q      <= host_we;
            bsel_q       <= host_addr[0];
            mem_addr_q   <= host_addr[ADDRESS_WIDTH-1:1];
            state_q      <= ISSUE;
            if (host_we) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= {host_wdata, holding_q};
            end
            if (disp_ok) last_disp_q <= 1'b0;
          end
        end
        ISSUE: begin
          if (op_wr_q) begin
            host_ack_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            state_q <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (owner_disp_q) begin
            disp_rdata_q <= mem_rdata;
            disp_ack_q   <= 1'b1;
          end else begin
            host_rdata_q <= bsel_q ? mem_rdata[CORE_WIDTH-1:DATA_WIDTH]
                                   : mem_rdata[DATA_WIDTH-1:0];
            host_ack_q   <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign host_rdata = host_rdata_q;
  assign host_ack   = host_ack_q;
  assign disp_rdata = disp_rdata_q;
  assign disp_ack   = disp_ack_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = (state_q != IDLE);

endmodule
